ro_measure_ctrl: RTL and testbench

RO_MEASURE_CTRL -- requirements
Module: ro_measure_ctrl

---
 rtl/ro_measure_ctrl.sv | 103 ++++++++++
 tb/tb_ro_measure_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: ring-oscillator gate-window sequencer; define RO_OVF_DET_EN to enable counter-wrap detection
module ro_measure_ctrl #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window_len,
   input  logic [CNT_W-1:0] count,
   output logic             ro_en,
   output logic             cnt_rst_n,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             overflow
);
   typedef enum logic [2:0] {IDLE, CLEAR, RUN, SETTLE, CAPTURE} state_t;
   state_t state_q, state_d;
   logic [WIN_W-1:0] win_q, win_d, wcnt_q, wcnt_d;
   logic ph_q, ph_d;
   logic [CNT_W-1:0] result_q;
   logic cap_en;
   assign ro_en     = state_q == RUN;
   assign cnt_rst_n = state_q != CLEAR;
   assign busy      = state_q != IDLE;
   assign done      = state_q == CAPTURE;
   assign result    = result_q;
   assign cap_en    = state_q == SETTLE && state_d == CAPTURE;
   // next-state: ph_q times the two-cycle CLEAR/SETTLE phases, wcnt_q times the gate window
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      wcnt_d  = wcnt_q;
      ph_d    = 1'b0;
      case (state_q)
         IDLE: if (start && !abort) begin
            state_d = CLEAR;
            win_d   = window_len == '0 ? WIN_W'(1) : window_len;
         end
         CLEAR: begin
            ph_d = !ph_q;
            if (ph_q) begin
               state_d = RUN;
               wcnt_d  = win_q;
            end
         end
         RUN: begin
            wcnt_d = wcnt_q - WIN_W'(1);
            if (wcnt_q == WIN_W'(1)) state_d = SETTLE;
         end
         SETTLE: begin
            ph_d = !ph_q;
            if (ph_q) state_d = CAPTURE;
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort && busy && state_q != CAPTURE) begin
         state_d = IDLE;
         ph_d    = 1'b0;
      end
   end
   // state, window and result registers; result only moves on entry to CAPTURE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         win_q    <= WIN_W'(1);
         wcnt_q   <= '0;
         ph_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         wcnt_q  <= wcnt_d;
         ph_q    <= ph_d;
         if (cap_en) result_q <= count;
      end
   end
`ifdef RO_OVF_DET_EN
   logic [2:0] msb_q;
   logic flag_q, flag_d, ovf_q;
   // sticky wrap flag: a synchronized MSB fall while gated means the counter rolled over
   always_comb flag_d = state_q == CLEAR ? 1'b0 :
                        flag_q | ((state_q == RUN || state_q == SETTLE) && msb_q[2] && !msb_q[1]);
   // two-flop MSB synchronizer plus a previous-sample stage that CLEAR zeroes so a stale high MSB cannot fake a wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msb_q  <= '0;
         flag_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         msb_q  <= {state_q == CLEAR ? 1'b0 : msb_q[1], msb_q[0], count[CNT_W-1]};
         flag_q <= flag_d;
         if (cap_en) ovf_q <= flag_d;
      end
   end
   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_ro_measure_ctrl.sv
// tb_ro_measure_ctrl: scoreboard bench for ro_measure_ctrl (honours RO_OVF_DET_EN)
module tb_ro_measure_ctrl;
   logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
   logic [15:0] window_len = '0;
   logic [7:0] count = '0;
   logic ro_en, cnt_rst_n, busy, done, overflow;
   logic [7:0] result;
   int cmp = 0, errs = 0, cyc = 0;
   typedef struct {int at; int res; int ovf; int ro;} exp_t;
   exp_t exp_q[$];
`ifdef RO_OVF_DET_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   ro_measure_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .window_len(window_len),
      .count(count), .ro_en(ro_en), .cnt_rst_n(cnt_rst_n), .busy(busy), .done(done),
      .result(result), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   // external edge counter: cleared by cnt_rst_n, one edge per RUN cycle
   always @(negedge clk) count = !cnt_rst_n ? 8'd0 : count + 8'(ro_en);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      cmp++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ro_en"}, ro_en, 0);
      chk({tag, "_cnt_rst_n"}, cnt_rst_n, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_overflow"}, overflow, 0);
   endtask

   task automatic do_start(input int w, input bit push);
      int n;
      @(negedge clk);
      start = 1'b1;
      window_len = w[15:0];
      n = (w == 0) ? 1 : w;
      if (push) exp_q.push_back('{cyc + 1 + n + 4, n % 256, int'(OVF_EN && n >= 256), n});
      @(posedge clk);
      #1 start = 1'b0;
      window_len = 16'($urandom);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) return;
      end
      cmp++;
      errs++;
      $display("FAIL done_timeout: got no done within 400 cycles, required a done pulse");
   endtask

   // monitor: per-measurement ro_en/clear cycle counts, checked against the queued expectation at done
   initial begin
      int ro = 0, clr = 0;
      bit last_crn = 1'b1;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!cnt_rst_n && last_crn) begin
            ro = 0;
            clr = 0;
         end
         if (!cnt_rst_n) clr++;
         if (ro_en) ro++;
         last_crn = cnt_rst_n;
         if (done) begin
            if (exp_q.size() == 0) begin
               cmp++;
               errs++;
               $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle", cyc, e.at);
               chk("result", result, e.res);
               chk("overflow", overflow, e.ovf);
               chk("ro_en_cycles", ro, e.ro);
               chk("clear_cycles", clr, 2);
            end
         end
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_start(10, 1);
      wait_done();
      do_start(20, 0);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("abort_pre_ro_en", ro_en, 1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_ro_en", ro_en, 0);
      chk("abort_cnt_rst_n", cnt_rst_n, 1);
      chk("abort_result_kept", result, 10);
      chk("abort_overflow_kept", overflow, 0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      abort = 1'b0;
      chk("start_abort_busy", busy, 0);
      do_start(0, 1);
      wait_done();
      do_start(300, 1);
      wait_done();
      do_start(8, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      repeat (20) @(posedge clk);
      do_start(5, 1);
      wait_done();
      do_start(3, 1);
      wait_done();
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         do_start(int'($urandom_range(0, 40)), 1);
         wait_done();
      end
      do_start(12, 0);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrun_reset");
      #2 rst_n = 1'b1;
      #1;
      do_start(7, 1);
      wait_done();
      repeat (5) @(posedge clk);
      chk("pending_expectations", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
